// File: rtl/camera_ctrl_master.sv
// -----------------------------------------------------------------------------
// camera_ctrl_master
//   Hardware Avalon-MM master that runs the camera bring-up/capture sequence
//   in place of software. On an accepted Start it writes the exposure value,
//   reads it back to verify it, starts configuration and polls for its done
//   bit, reads the frame-count baseline, starts capture, polls until the
//   requested number of frames has arrived, then stops capture.
//
//   Ports
//     Clock, Resetn          clock, asynchronous active-low reset
//     Start, Abort           sequence request / abort request (user side)
//     Exposure, Frame_target sequence arguments, latched on accepted Start
//     Busy, Done, Aborted,   sequence status; Done is a 1-cycle end pulse,
//     Error_code             Aborted/Error_code are held until the next Start
//     Frames_captured        frames seen since the baseline read (mod 2^32)
//     address, chipselect,   Avalon-MM master to the camera interface slave;
//     read, write, writedata the slave returns registered readdata, so a
//     readdata               read is 2 cycles: strobe, then sample at end
// -----------------------------------------------------------------------------
module camera_ctrl_master #(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned CFG_SETTLE  = 64,
  parameter int unsigned CFG_TIMEOUT = 1000000,
  parameter int unsigned FRM_TIMEOUT = 50000000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Abort,
  input  logic [15:0] Exposure,
  input  logic [31:0] Frame_target,
  output logic        Busy,
  output logic        Done,
  output logic        Aborted,
  output logic [1:0]  Error_code,
  output logic [31:0] Frames_captured,
  output logic [3:0]  address,
  output logic        chipselect,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_EXP, S_RD_EXP, S_CFG_GO, S_POLL_CFG,
    S_RD_BASE, S_CAP_GO, S_POLL_FRM, S_CAP_STOP, S_FIN
  } state_e;

  localparam logic [1:0] ERR_EXP = 2'd1;
  localparam logic [1:0] ERR_CFG = 2'd2;
  localparam logic [1:0] ERR_FRM = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // cycles in current state, saturating
  logic [31:0] phase_q, phase_d;   // position inside one poll period
  logic [15:0] exp_q, exp_d;
  logic [31:0] target_q, target_d;
  logic [31:0] base_q, base_d;
  logic [31:0] frames_q, frames_d;
  logic [1:0]  err_q, err_d;
  logic        aborted_q, aborted_d;
  logic        abort_q, abort_d;   // remembers an Abort pulse until a decision point
  logic        abort_pend;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      exp_q     <= '0;
      target_q  <= '0;
      base_q    <= '0;
      frames_q  <= '0;
      err_q     <= '0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      exp_q     <= exp_d;
      target_q  <= target_d;
      base_q    <= base_d;
      frames_q  <= frames_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Decisions are only taken once the current bus
  // transaction has finished (write states at cnt 1, polls at phase >= 1).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    exp_d      = exp_q;
    target_d   = target_q;
    base_d     = base_q;
    frames_d   = frames_q;
    err_d      = err_q;
    aborted_d  = aborted_q;
    abort_pend = abort_q | Abort;
    abort_d    = abort_q | (Abort && (state_q inside {S_WR_EXP, S_RD_EXP, S_CFG_GO,
                 S_POLL_CFG, S_RD_BASE, S_CAP_GO, S_POLL_FRM}));

    unique case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_d   = S_WR_EXP;
          exp_d     = Exposure;
          target_d  = Frame_target;
          frames_d  = '0;
          err_d     = '0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
        end
      end
      S_WR_EXP: begin
        if (cnt_q == 32'd1) begin
          if (abort_pend) begin state_d = S_FIN; aborted_d = 1'b1; end
          else            state_d = S_RD_EXP;
        end
      end
      S_RD_EXP: begin
        if (cnt_q == 32'd1) begin
          if (abort_pend)                    begin state_d = S_FIN; aborted_d = 1'b1; end
          else if (readdata[15:0] != exp_q)  begin state_d = S_FIN; err_d = ERR_EXP; end
          else                               state_d = S_CFG_GO;
        end
      end
      S_CFG_GO: begin
        if (cnt_q != 32'd0) begin
          if (abort_pend)               begin state_d = S_FIN; aborted_d = 1'b1; end
          else if (cnt_q >= CFG_SETTLE) state_d = S_POLL_CFG;
        end
      end
      S_POLL_CFG: begin
        if (phase_q != 32'd0) begin
          if (abort_pend)                        begin state_d = S_FIN; aborted_d = 1'b1; end
          else if (phase_q == 32'd1 && readdata[0]) state_d = S_RD_BASE;
          else if (cnt_q > CFG_TIMEOUT)          begin state_d = S_FIN; err_d = ERR_CFG; end
        end
      end
      S_RD_BASE: begin
        if (cnt_q == 32'd1) begin
          if (abort_pend) begin state_d = S_FIN; aborted_d = 1'b1; end
          else begin
            base_d  = readdata;
            state_d = S_CAP_GO;
          end
        end
      end
      S_CAP_GO: begin
        if (cnt_q == 32'd1) begin
          if (abort_pend)               begin state_d = S_CAP_STOP; aborted_d = 1'b1; end
          else if (target_q == 32'd0)   state_d = S_CAP_STOP;
          else                          state_d = S_POLL_FRM;
        end
      end
      S_POLL_FRM: begin
        if (phase_q != 32'd0) begin
          // Modular subtract keeps the count right across a frame-counter wrap.
          if (phase_q == 32'd1) frames_d = readdata - base_q;
          if (phase_q == 32'd1 && frames_d >= target_q) state_d = S_CAP_STOP;
          else if (abort_pend)          begin state_d = S_CAP_STOP; aborted_d = 1'b1; end
          else if (cnt_q > FRM_TIMEOUT) begin state_d = S_CAP_STOP; err_d = ERR_FRM; end
        end
      end
      S_CAP_STOP: begin
        if (cnt_q == 32'd1) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Timing counters restart on every state entry.
    if (state_d != state_q) begin
      cnt_d   = '0;
      phase_d = '0;
    end else begin
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
      phase_d = (phase_q >= POLL_GAP + 32'd1) ? 32'd0 : phase_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic. Bus strobes are decoded from registered state only, so reset
  // drops them in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 4'd0;
    writedata  = 32'd0;

    unique case (state_q)
      S_WR_EXP:   if (cnt_q == 32'd0)   begin chipselect = 1'b1; write = 1'b1; address = 4'd0; writedata = {16'h0, exp_q}; end
      S_RD_EXP:   if (cnt_q == 32'd0)   begin chipselect = 1'b1; read  = 1'b1; address = 4'd0; end
      S_CFG_GO:   if (cnt_q == 32'd0)   begin chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h2; end
      S_POLL_CFG: if (phase_q == 32'd0) begin chipselect = 1'b1; read  = 1'b1; address = 4'd1; end
      S_RD_BASE:  if (cnt_q == 32'd0)   begin chipselect = 1'b1; read  = 1'b1; address = 4'd2; end
      S_CAP_GO:   if (cnt_q == 32'd0)   begin chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h4; end
      S_POLL_FRM: if (phase_q == 32'd0) begin chipselect = 1'b1; read  = 1'b1; address = 4'd2; end
      S_CAP_STOP: if (cnt_q == 32'd0)   begin chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h8; end
      default: ;
    endcase

    Busy            = !(state_q inside {S_IDLE, S_FIN});
    Done            = (state_q == S_FIN);
    Aborted         = aborted_q;
    Error_code      = err_q;
    Frames_captured = frames_q;
  end

endmodule

// File: tb/tb_camera_ctrl_master.sv
// -----------------------------------------------------------------------------
// tb_camera_ctrl_master
//   Directed bench for camera_ctrl_master with a behavioural camera slave
//   (exposure register, config-done status, free-running frame counter) and a
//   bus protocol monitor.
// -----------------------------------------------------------------------------
module tb_camera_ctrl_master;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] Exposure = '0;
  logic [31:0] Frame_target = '0;
  logic        Busy, Done, Aborted;
  logic [1:0]  Error_code;
  logic [31:0] Frames_captured;
  logic [3:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  camera_ctrl_master #(
    .POLL_GAP(2), .CFG_SETTLE(4), .CFG_TIMEOUT(500), .FRM_TIMEOUT(2000)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
    .Exposure(Exposure), .Frame_target(Frame_target),
    .Busy(Busy), .Done(Done), .Aborted(Aborted), .Error_code(Error_code),
    .Frames_captured(Frames_captured), .address(address),
    .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );

  // ---------------------------------------------------------------------------
  // Camera slave model
  // ---------------------------------------------------------------------------
  logic [35:0] wlog[$];          // {address, writedata} of every write
  logic [15:0] exp_reg = '0;
  logic        exp_ovr_en = 1'b0;
  logic [15:0] exp_ovr = '0;
  logic        cfg_never = 1'b0;
  int          cfg_delay = 100;
  int          cfg_cnt = 0;
  logic        cfg_run = 1'b0;
  logic        cfg_done = 1'b0;
  logic        capturing = 1'b0;
  logic [31:0] fc = '0;
  int          fc_period = 20;
  int          fc_tick = 0;

  always @(posedge Clock) begin
    if (chipselect && read) begin
      case (address)
        4'd0:    readdata <= {16'h0, exp_ovr_en ? exp_ovr : exp_reg};
        4'd1:    readdata <= {31'h0, cfg_done};
        4'd2:    readdata <= fc;
        default: readdata <= 32'h0;
      endcase
    end
    if (cfg_run && !cfg_never) begin
      cfg_cnt = cfg_cnt + 1;
      if (cfg_cnt >= cfg_delay) cfg_done = 1'b1;
    end
    if (capturing) begin
      fc_tick = fc_tick + 1;
      if (fc_tick >= fc_period) begin fc_tick = 0; fc = fc + 32'd1; end
    end
    if (chipselect && write) begin
      wlog.push_back({address, writedata});
      if (address == 4'd0) exp_reg = writedata[15:0];
      if (address == 4'd1) begin
        if (writedata[1]) begin cfg_run = 1'b1; cfg_cnt = 0; cfg_done = 1'b0; end
        if (writedata[2]) capturing = 1'b1;
        if (writedata[3]) capturing = 1'b0;
      end
    end
  end

  // Bus protocol monitor, sampled mid-cycle.
  int   bus_viol = 0;
  logic prev_cs = 1'b0;
  always @(negedge Clock) begin
    if (!write && writedata != 32'h0)               bus_viol++;
    if ((read || write) && !chipselect)             bus_viol++;
    if (read && write)                              bus_viol++;
    if (chipselect && prev_cs)                      bus_viol++;
    if (write && address == 4'd1 && !$onehot(writedata)) bus_viol++;
    prev_cs = chipselect;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] e, input logic [31:0] t);
    @(negedge Clock);
    Exposure = e; Frame_target = t; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Returns on the negedge where Done is high (or after the budget expires).
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (Done !== 1'b1 && n < budget) begin @(negedge Clock); n++; end
    check(tag, Done, 1'b1);
  endtask

  task automatic wait_cmd(input string tag, input logic [31:0] data, input int budget);
    int n = 0;
    while (!(write === 1'b1 && writedata === data) && n < budget) begin @(negedge Clock); n++; end
    check(tag, write, 1'b1);
  endtask

  task automatic pulse_abort();
    @(negedge Clock); Abort = 1'b1;
    @(negedge Clock); Abort = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #12;
    check("rst_busy",  Busy, 1'b0);
    check("rst_done",  Done, 1'b0);
    check("rst_err",   Error_code, 2'd0);
    check("rst_bus",   {chipselect, read, write, address, writedata}, 39'd0);
    check("rst_frm",   Frames_captured, 32'd0);
    @(negedge Clock); Resetn = 1'b1;

    // 1: nominal run, fc 10 -> 13
    fc = 32'd10; fc_tick = 0; fc_period = 20; cfg_delay = 100;
    wlog.delete();
    do_start(16'h0200, 32'd3);
    check("t1_busy", Busy, 1'b1);
    wait_done("t1_done", 3000);
    check("t1_busy_at_done", Busy, 1'b0);
    check("t1_err",   Error_code, 2'd0);
    check("t1_abort", Aborted, 1'b0);
    check("t1_frames", Frames_captured, 32'd3);
    check("t1_nwr",  wlog.size(), 4);
    check("t1_wr0",  wlog[0], {4'd0, 32'h0000_0200});
    check("t1_wr1",  wlog[1], {4'd1, 32'h2});
    check("t1_wr2",  wlog[2], {4'd1, 32'h4});
    check("t1_wr3",  wlog[3], {4'd1, 32'h8});
    @(negedge Clock);
    check("t1_done_pulse", Done, 1'b0);

    // 5: Start together with Abort in IDLE is ignored
    wlog.delete();
    @(negedge Clock); Start = 1'b1; Abort = 1'b1;
    @(negedge Clock); Start = 1'b0; Abort = 1'b0;
    repeat (3) @(negedge Clock);
    check("t5_busy", Busy, 1'b0);
    check("t5_nwr",  wlog.size(), 0);

    // 2: frame counter wraps
    fc = 32'hFFFF_FFFE; fc_tick = 0;
    wlog.delete();
    do_start(16'h0123, 32'd4);
    wait_done("t2_done", 3000);
    check("t2_err",    Error_code, 2'd0);
    check("t2_frames", Frames_captured, 32'd4);
    check("t2_wr3",    wlog[3], {4'd1, 32'h8});

    // 3: exposure readback mismatch
    exp_ovr_en = 1'b1; exp_ovr = 16'h0100;
    wlog.delete();
    do_start(16'h0200, 32'd3);
    wait_done("t3_done", 200);
    check("t3_err", Error_code, 2'd1);
    check("t3_nwr", wlog.size(), 1);
    exp_ovr_en = 1'b0;

    // Frame_target == 0: start then stop immediately
    wlog.delete();
    do_start(16'h0042, 32'd0);
    wait_done("t0_done", 1000);
    check("t0_err",    Error_code, 2'd0);
    check("t0_frames", Frames_captured, 32'd0);
    check("t0_nwr",    wlog.size(), 4);
    check("t0_wr3",    wlog[3], {4'd1, 32'h8});

    // 4a: config never completes
    cfg_never = 1'b1;
    wlog.delete();
    do_start(16'h0200, 32'd3);
    wait_done("t4a_done", 2000);
    check("t4a_err", Error_code, 2'd2);
    check("t4a_nwr", wlog.size(), 2);

    // Abort while polling config: finish without capture writes
    wlog.delete();
    do_start(16'h0200, 32'd3);
    repeat (20) @(negedge Clock);
    pulse_abort();
    wait_done("ab_cfg_done", 200);
    check("ab_cfg_aborted", Aborted, 1'b1);
    check("ab_cfg_err",     Error_code, 2'd0);
    check("ab_cfg_nwr",     wlog.size(), 2);
    cfg_never = 1'b0;

    // 4b: Abort after capture start -> stop, then Done with Aborted
    fc_period = 100000;
    wlog.delete();
    do_start(16'h0200, 32'd100);
    wait_cmd("t4b_capgo", 32'h4, 2000);
    pulse_abort();
    wait_done("t4b_done", 200);
    check("t4b_aborted", Aborted, 1'b1);
    check("t4b_nwr",     wlog.size(), 4);
    check("t4b_wr3",     wlog[3], {4'd1, 32'h8});

    // Frame polling timeout
    wlog.delete();
    do_start(16'h0200, 32'd5);
    wait_done("tfr_done", 5000);
    check("tfr_err",     Error_code, 2'd3);
    check("tfr_aborted", Aborted, 1'b0);
    check("tfr_wr3",     wlog[3], {4'd1, 32'h8});

    // 6: reset in the middle of frame polling
    wlog.delete();
    do_start(16'h0200, 32'd100);
    wait_cmd("t6_capgo", 32'h4, 2000);
    begin
      int n = 0;
      while (read !== 1'b1 && n < 50) begin @(negedge Clock); n++; end
    end
    check("t6_read_seen", read, 1'b1);
    #1 Resetn = 1'b0;
    #1;
    check("t6_bus_rst",  {chipselect, read, write, address, writedata}, 39'd0);
    check("t6_busy_rst", Busy, 1'b0);
    @(negedge Clock); Resetn = 1'b1;
    wlog.delete();
    do_start(16'h0033, 32'd5);
    begin
      int n = 0;
      while (write !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
    end
    check("t6_restart_wr", {write, address, writedata}, {1'b1, 4'd0, 32'h0000_0033});

    check("bus_protocol", bus_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
